// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control path: ALU field codes, opcode/funct values,
// operand-source selects and forward-select values.
// Purely declarative, so it adds no latency and has no flow control.
package alu_pkg;

   typedef enum logic [1:0] {SH_SLL = 2'd0, SH_SRL = 2'd1, SH_SRA = 2'd2, SH_ROR = 2'd3} shift_op_e;
   typedef enum logic       {AR_ADD = 1'b0, AR_SUB = 1'b1} arith_op_e;
   typedef enum logic [1:0] {LG_AND = 2'd0, LG_OR = 2'd1, LG_NOR = 2'd2, LG_XOR = 2'd3} logic_op_e;
   typedef enum logic [1:0] {SEL_SHIFT = 2'd0, SEL_SLT = 2'd1, SEL_ARITH = 2'd2, SEL_LOGIC = 2'd3} select_e;

   // Operand sources chosen by the decoder; only the *_RS / *_RT sources are forwardable.
   typedef enum logic [1:0] {SRC1_ZERO = 2'd0, SRC1_RS = 2'd1, SRC1_SHAMT = 2'd2, SRC1_C16 = 2'd3} src1_e;
   typedef enum logic [1:0] {SRC2_ZERO = 2'd0, SRC2_RT = 2'd1, SRC2_SIMM = 2'd2, SRC2_ZIMM = 2'd3} src2_e;

   // Forward selects; value 3 falls back to the registered operand.
   localparam logic [1:0] FWD_REG   = 2'd0;
   localparam logic [1:0] FWD_EXMEM = 2'd1;
   localparam logic [1:0] FWD_MEMWB = 2'd2;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_SRA  = 6'h03;
   localparam logic [5:0] F_SLLV = 6'h04;
   localparam logic [5:0] F_SRLV = 6'h06;
   localparam logic [5:0] F_SRAV = 6'h07;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_XOR  = 6'h26;
   localparam logic [5:0] F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2A;
   localparam logic [5:0] F_SLTU = 6'h2B;

   // ALU control fields as held in the ID/EX register.
   typedef struct packed {
      logic [1:0] shift_op;
      logic       arith_op;
      logic [1:0] logic_op;
      logic [1:0] sel;
      logic       sign;
   } ctrl_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Instruction decoder: opcode/funct -> ALU control fields, operand sources, illegal, trap.
// Purely combinational, zero latency.
// No flow control; the enclosing pipeline stage handles stall/flush.
// Ports: opcode, funct, rot (instr[21]), shamt_lsb in; ALU fields, src1_sel, src2_sel, illegal, trap out.
// Macro ALU_CTRL_ROTATE_EN: when defined, funct 02/06 may decode to ROR.
module alu_ctrl_decode
   import alu_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       rot,
   input  logic       shamt_lsb,
   output logic [1:0] shift_op,
   output logic       arith_op,
   output logic [1:0] logic_op,
   output logic [1:0] sel,
   output logic       sign,
   output logic [1:0] src1_sel,
   output logic [1:0] src2_sel,
   output logic       illegal,
   output logic       trap
);

   logic ror_imm;
   logic ror_var;

`ifdef ALU_CTRL_ROTATE_EN
   assign ror_imm = rot;
   assign ror_var = shamt_lsb;
`else
   logic unused_rot;
   assign unused_rot = ^{rot, shamt_lsb};
   assign ror_imm    = 1'b0;
   assign ror_var    = 1'b0;
`endif

   always_comb begin
      // Defaults are the NOP controls (SLL, SHIFT, zero operands).
      shift_op = SH_SLL;
      arith_op = AR_ADD;
      logic_op = LG_AND;
      sel      = SEL_SHIFT;
      sign     = 1'b0;
      src1_sel = SRC1_ZERO;
      src2_sel = SRC2_ZERO;
      illegal  = 1'b0;
      trap     = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            src1_sel = SRC1_RS;
            src2_sel = SRC2_RT;
            case (funct)
               F_SLL:  src1_sel = SRC1_SHAMT;
               F_SRL:  begin src1_sel = SRC1_SHAMT; shift_op = ror_imm ? SH_ROR : SH_SRL; end
               F_SRA:  begin src1_sel = SRC1_SHAMT; shift_op = SH_SRA; end
               F_SLLV: shift_op = SH_SLL;
               F_SRLV: shift_op = ror_var ? SH_ROR : SH_SRL;
               F_SRAV: shift_op = SH_SRA;
               F_ADD:  begin sel = SEL_ARITH; trap = 1'b1; end
               F_ADDU: sel = SEL_ARITH;
               F_SUB:  begin sel = SEL_ARITH; arith_op = AR_SUB; trap = 1'b1; end
               F_SUBU: begin sel = SEL_ARITH; arith_op = AR_SUB; end
               F_AND:  begin sel = SEL_LOGIC; logic_op = LG_AND; end
               F_OR:   begin sel = SEL_LOGIC; logic_op = LG_OR;  end
               F_XOR:  begin sel = SEL_LOGIC; logic_op = LG_XOR; end
               F_NOR:  begin sel = SEL_LOGIC; logic_op = LG_NOR; end
               F_SLT:  begin sel = SEL_SLT; arith_op = AR_SUB; sign = 1'b1; end
               F_SLTU: begin sel = SEL_SLT; arith_op = AR_SUB; end
               default: begin
                  src1_sel = SRC1_ZERO;
                  src2_sel = SRC2_ZERO;
                  illegal  = 1'b1;
               end
            endcase
         end
         OP_ADDI:  begin src1_sel = SRC1_RS; src2_sel = SRC2_SIMM; sel = SEL_ARITH; trap = 1'b1; end
         OP_ADDIU: begin src1_sel = SRC1_RS; src2_sel = SRC2_SIMM; sel = SEL_ARITH; end
         OP_SLTI:  begin src1_sel = SRC1_RS; src2_sel = SRC2_SIMM; sel = SEL_SLT; arith_op = AR_SUB; sign = 1'b1; end
         OP_SLTIU: begin src1_sel = SRC1_RS; src2_sel = SRC2_SIMM; sel = SEL_SLT; arith_op = AR_SUB; end
         OP_ANDI:  begin src1_sel = SRC1_RS; src2_sel = SRC2_ZIMM; sel = SEL_LOGIC; logic_op = LG_AND; end
         OP_ORI:   begin src1_sel = SRC1_RS; src2_sel = SRC2_ZIMM; sel = SEL_LOGIC; logic_op = LG_OR;  end
         OP_XORI:  begin src1_sel = SRC1_RS; src2_sel = SRC2_ZIMM; sel = SEL_LOGIC; logic_op = LG_XOR; end
         // LUI is realised as (imm << 16) on the shifter.
         OP_LUI:   begin src1_sel = SRC1_C16; src2_sel = SRC2_ZIMM; end
         OP_LW,
         OP_SW:    begin src1_sel = SRC1_RS; src2_sel = SRC2_SIMM; sel = SEL_ARITH; end
         OP_BEQ,
         OP_BNE:   begin src1_sel = SRC1_RS; src2_sel = SRC2_RT; sel = SEL_ARITH; arith_op = AR_SUB; end
         default:  illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_ctrl_idex.sv
// ID/EX stage feeding the ALU: decode, operand build, pipeline register, EX forwarding.
// One cycle ID to outputs; forwarding muxes are combinational after the register.
// i_stall holds the register, i_flush (higher priority) loads a bubble; no handshake.
// Ports: i_clk, i_rst_n, ID inputs (i_valid, i_stall, i_flush, instr fields, rs/rt data),
//        forward selects and bypass data in; ALU operands/control, o_ovf_trap, o_valid, o_illegal out.
// Macro ALU_CTRL_ROTATE_EN (via alu_ctrl_decode): enables ROTR/ROTRV decode.
module alu_ctrl_idex #(
   parameter int WIDTH  = 32,
   parameter int FWD_EN = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   input  logic             i_stall,
   input  logic             i_flush,
   input  logic [5:0]       i_opcode,
   input  logic [5:0]       i_funct,
   input  logic [4:0]       i_shamt,
   input  logic             i_rot,
   input  logic [15:0]      i_imm,
   input  logic [WIDTH-1:0] i_rs_data,
   input  logic [WIDTH-1:0] i_rt_data,
   input  logic [1:0]       i_fwd_a,
   input  logic [1:0]       i_fwd_b,
   input  logic [WIDTH-1:0] i_exmem_data,
   input  logic [WIDTH-1:0] i_memwb_data,
   output logic [WIDTH-1:0] o_data1,
   output logic [WIDTH-1:0] o_data2,
   output logic [1:0]       o_shift_op,
   output logic             o_arith_op,
   output logic [1:0]       o_logic_op,
   output logic [1:0]       o_select,
   output logic             o_sign,
   output logic             o_ovf_trap,
   output logic             o_valid,
   output logic             o_illegal
);
   import alu_pkg::*;

   ctrl_t      dec_ctrl;
   logic [1:0] src1_sel;
   logic [1:0] src2_sel;
   logic       dec_illegal;
   logic       dec_trap;

   alu_ctrl_decode u_decode (
      .opcode    (i_opcode),
      .funct     (i_funct),
      .rot       (i_rot),
      .shamt_lsb (i_shamt[0]),
      .shift_op  (dec_ctrl.shift_op),
      .arith_op  (dec_ctrl.arith_op),
      .logic_op  (dec_ctrl.logic_op),
      .sel       (dec_ctrl.sel),
      .sign      (dec_ctrl.sign),
      .src1_sel  (src1_sel),
      .src2_sel  (src2_sel),
      .illegal   (dec_illegal),
      .trap      (dec_trap)
   );

   logic [WIDTH-1:0] op1_d;
   logic [WIDTH-1:0] op2_d;

   always_comb begin
      case (src1_sel)
         SRC1_RS:    op1_d = i_rs_data;
         SRC1_SHAMT: op1_d = {{(WIDTH-5){1'b0}}, i_shamt};
         SRC1_C16:   op1_d = WIDTH'(16);
         default:    op1_d = '0;
      endcase
      case (src2_sel)
         SRC2_RT:   op2_d = i_rt_data;
         SRC2_SIMM: op2_d = {{(WIDTH-16){i_imm[15]}}, i_imm};
         SRC2_ZIMM: op2_d = {{(WIDTH-16){1'b0}}, i_imm};
         default:   op2_d = '0;
      endcase
   end

   ctrl_t            ctrl_q;
   logic [WIDTH-1:0] d1_q;
   logic [WIDTH-1:0] d2_q;
   logic             src1_reg_q;
   logic             src2_reg_q;
   logic             valid_q;
   logic             illegal_q;
   logic             trap_q;

   // A flush loads the same all-zero bubble as reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ctrl_q     <= '0;
         d1_q       <= '0;
         d2_q       <= '0;
         src1_reg_q <= 1'b0;
         src2_reg_q <= 1'b0;
         valid_q    <= 1'b0;
         illegal_q  <= 1'b0;
         trap_q     <= 1'b0;
      end else if (i_flush) begin
         ctrl_q     <= '0;
         d1_q       <= '0;
         d2_q       <= '0;
         src1_reg_q <= 1'b0;
         src2_reg_q <= 1'b0;
         valid_q    <= 1'b0;
         illegal_q  <= 1'b0;
         trap_q     <= 1'b0;
      end else if (!i_stall) begin
         ctrl_q     <= dec_ctrl;
         d1_q       <= op1_d;
         d2_q       <= op2_d;
         src1_reg_q <= (src1_sel == SRC1_RS);
         src2_reg_q <= (src2_sel == SRC2_RT);
         valid_q    <= i_valid;
         illegal_q  <= dec_illegal & i_valid;
         trap_q     <= dec_trap & i_valid;
      end
   end

   // Forwarding stays live during a stall so a held instruction sees fresh bypass data.
   always_comb begin
      o_data1 = d1_q;
      o_data2 = d2_q;
      if (FWD_EN != 0) begin
         if (src1_reg_q) begin
            case (i_fwd_a)
               FWD_EXMEM: o_data1 = i_exmem_data;
               FWD_MEMWB: o_data1 = i_memwb_data;
               default:   o_data1 = d1_q;
            endcase
         end
         if (src2_reg_q) begin
            case (i_fwd_b)
               FWD_EXMEM: o_data2 = i_exmem_data;
               FWD_MEMWB: o_data2 = i_memwb_data;
               default:   o_data2 = d2_q;
            endcase
         end
      end
   end

   assign o_shift_op = ctrl_q.shift_op;
   assign o_arith_op = ctrl_q.arith_op;
   assign o_logic_op = ctrl_q.logic_op;
   assign o_select   = ctrl_q.sel;
   assign o_sign     = ctrl_q.sign;
   assign o_ovf_trap = trap_q;
   assign o_valid    = valid_q;
   assign o_illegal  = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_idex.sv
// Bench for alu_ctrl_idex: directed scenarios then randomized traffic against a reference model.
// Inputs change on the falling edge; outputs are compared on the next falling edge.
// Reference model: instruction table -> expected ALU fields, plus stall/flush/forward rules.
module tb_alu_ctrl_idex;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_valid, i_stall, i_flush, i_rot;
   logic [5:0]  i_opcode, i_funct;
   logic [4:0]  i_shamt;
   logic [15:0] i_imm;
   logic [31:0] i_rs_data, i_rt_data, i_exmem_data, i_memwb_data;
   logic [1:0]  i_fwd_a, i_fwd_b;
   logic [31:0] o_data1, o_data2;
   logic [1:0]  o_shift_op, o_logic_op, o_select;
   logic        o_arith_op, o_sign, o_ovf_trap, o_valid, o_illegal;

   alu_ctrl_idex #(.WIDTH(32), .FWD_EN(1)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_stall(i_stall), .i_flush(i_flush),
      .i_opcode(i_opcode), .i_funct(i_funct), .i_shamt(i_shamt), .i_rot(i_rot), .i_imm(i_imm),
      .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_fwd_a(i_fwd_a), .i_fwd_b(i_fwd_b),
      .i_exmem_data(i_exmem_data), .i_memwb_data(i_memwb_data),
      .o_data1(o_data1), .o_data2(o_data2), .o_shift_op(o_shift_op), .o_arith_op(o_arith_op),
      .o_logic_op(o_logic_op), .o_select(o_select), .o_sign(o_sign), .o_ovf_trap(o_ovf_trap),
      .o_valid(o_valid), .o_illegal(o_illegal)
   );

   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic [31:0] d1;
      logic [31:0] d2;
      logic [1:0]  sh;
      logic        ar;
      logic [1:0]  lg;
      logic [1:0]  sel;
      logic        sg;
      logic        trap;
      logic        ill;
      logic        s1r;
      logic        s2r;
      logic        vld;
   } m_t;

   m_t st;
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Expected ID/EX content for one instruction, straight from the ISA table.
   function automatic m_t ref_decode(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sa,
                                     input logic rot, input logic [15:0] imm,
                                     input logic [31:0] rs, input logic [31:0] rt);
      m_t m;
      logic [31:0] sx, zx;
      sx = {{16{imm[15]}}, imm};
      zx = {16'h0000, imm};
      m = '0;
      m.ill = 1'b1;
      if (op == 6'h00) begin
         if (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) begin
            m.ill = 0; m.d1 = {27'd0, sa}; m.d2 = rt; m.s2r = 1;
            m.sh = (fn == 6'h00) ? 2'd0 : (fn == 6'h03) ? 2'd2 : 2'd1;
`ifdef ALU_CTRL_ROTATE_EN
            if (fn == 6'h02 && rot) m.sh = 2'd3;
`endif
         end else if (fn == 6'h04 || fn == 6'h06 || fn == 6'h07) begin
            m.ill = 0; m.d1 = rs; m.d2 = rt; m.s1r = 1; m.s2r = 1;
            m.sh = (fn == 6'h04) ? 2'd0 : (fn == 6'h07) ? 2'd2 : 2'd1;
`ifdef ALU_CTRL_ROTATE_EN
            if (fn == 6'h06 && sa[0]) m.sh = 2'd3;
`endif
         end else if (fn >= 6'h20 && fn <= 6'h27 || fn == 6'h2A || fn == 6'h2B) begin
            m.ill = 0; m.d1 = rs; m.d2 = rt; m.s1r = 1; m.s2r = 1;
            if (fn <= 6'h23) begin
               m.sel = 2'd2; m.ar = (fn == 6'h22 || fn == 6'h23);
               m.trap = (fn == 6'h20 || fn == 6'h22);
            end else if (fn <= 6'h27) begin
               m.sel = 2'd3;
               m.lg = (fn == 6'h24) ? 2'd0 : (fn == 6'h25) ? 2'd1 : (fn == 6'h26) ? 2'd3 : 2'd2;
            end else begin
               m.sel = 2'd1; m.ar = 1; m.sg = (fn == 6'h2A);
            end
         end
      end else if (op >= 6'h08 && op <= 6'h0B) begin
         m.ill = 0; m.d1 = rs; m.s1r = 1; m.d2 = sx;
         if (op <= 6'h09) begin m.sel = 2'd2; m.trap = (op == 6'h08); end
         else begin m.sel = 2'd1; m.ar = 1; m.sg = (op == 6'h0A); end
      end else if (op >= 6'h0C && op <= 6'h0E) begin
         m.ill = 0; m.d1 = rs; m.s1r = 1; m.d2 = zx; m.sel = 2'd3;
         m.lg = (op == 6'h0C) ? 2'd0 : (op == 6'h0D) ? 2'd1 : 2'd3;
      end else if (op == 6'h0F) begin
         m.ill = 0; m.d1 = 32'd16; m.d2 = zx;
      end else if (op == 6'h23 || op == 6'h2B) begin
         m.ill = 0; m.d1 = rs; m.s1r = 1; m.d2 = sx; m.sel = 2'd2;
      end else if (op == 6'h04 || op == 6'h05) begin
         m.ill = 0; m.d1 = rs; m.d2 = rt; m.s1r = 1; m.s2r = 1; m.sel = 2'd2; m.ar = 1;
      end
      return m;
   endfunction

   function automatic logic [31:0] fwd(input logic en, input logic [1:0] s, input logic [31:0] r);
      if (en && s == 2'd1) return i_exmem_data;
      if (en && s == 2'd2) return i_memwb_data;
      return r;
   endfunction

   task automatic compare_all(input string tag);
      check({tag, "_data1"}, o_data1, fwd(st.s1r, i_fwd_a, st.d1));
      check({tag, "_data2"}, o_data2, fwd(st.s2r, i_fwd_b, st.d2));
      check({tag, "_shift"}, 32'(o_shift_op), 32'(st.sh));
      check({tag, "_arith"}, 32'(o_arith_op), 32'(st.ar));
      check({tag, "_logic"}, 32'(o_logic_op), 32'(st.lg));
      check({tag, "_select"}, 32'(o_select), 32'(st.sel));
      check({tag, "_sign"}, 32'(o_sign), 32'(st.sg));
      check({tag, "_trap"}, 32'(o_ovf_trap), 32'(st.trap));
      check({tag, "_valid"}, 32'(o_valid), 32'(st.vld));
      check({tag, "_illegal"}, 32'(o_illegal), 32'(st.ill));
   endtask

   // Advance the model by one clock using the current inputs, clock the DUT, compare.
   task automatic cycle(input string tag);
      m_t nxt;
      nxt = ref_decode(i_opcode, i_funct, i_shamt, i_rot, i_imm, i_rs_data, i_rt_data);
      if (!i_rst_n || i_flush) st = '0;
      else if (!i_stall) begin
         st = nxt;
         st.vld  = i_valid;
         st.ill  = nxt.ill & i_valid;
         st.trap = nxt.trap & i_valid;
      end
      @(posedge i_clk);
      @(negedge i_clk);
      compare_all(tag);
   endtask

   task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sa, input logic rot,
                        input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt, input logic vld);
      i_opcode = op; i_funct = fn; i_shamt = sa; i_rot = rot; i_imm = imm;
      i_rs_data = rs; i_rt_data = rt; i_valid = vld;
      i_stall = 0; i_flush = 0; i_fwd_a = 0; i_fwd_b = 0;
   endtask

   logic [5:0] ops [13] = '{6'h00, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
   logic [5:0] fns [16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                            6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

   initial begin
      st = '0;
      i_rst_n = 0;
      drive(6'h08, 6'h00, 5'd0, 1'b0, 16'h1111, 32'h1, 32'h2, 1'b1);
      i_exmem_data = 32'h0; i_memwb_data = 32'h0;
      @(negedge i_clk);
      compare_all("reset");
      @(negedge i_clk);
      i_rst_n = 1;

      // ADDI with negative immediate.
      drive(6'h08, 6'h00, 5'd0, 1'b0, 16'hFFFF, 32'd5, 32'd0, 1'b1);
      cycle("addi");
      check("addi_data2_const", o_data2, 32'hFFFF_FFFF);
      check("addi_trap_const", 32'(o_ovf_trap), 32'd1);

      // SRA by shamt, then forward rt from EX/MEM.
      drive(6'h00, 6'h03, 5'd4, 1'b0, 16'h0000, 32'd0, 32'h8000_0000, 1'b1);
      cycle("sra");
      i_fwd_b = 2'd1; i_exmem_data = 32'd7;
      #1 compare_all("sra_fwd");
      check("sra_fwd_data2_const", o_data2, 32'd7);

      // LUI: the constant 16 is never forwarded.
      drive(6'h0F, 6'h00, 5'd0, 1'b0, 16'h1234, 32'hAAAA_AAAA, 32'd0, 1'b1);
      i_fwd_a = 2'd1; i_exmem_data = 32'hDEAD_BEEF;
      cycle("lui");
      check("lui_data1_const", o_data1, 32'd16);

      // SLTU then a 3-cycle stall with flush on the second stall cycle.
      drive(6'h00, 6'h2B, 5'd0, 1'b0, 16'h0000, 32'd3, 32'd9, 1'b1);
      cycle("sltu");
      drive(6'h08, 6'h00, 5'd0, 1'b0, 16'h0005, 32'd1, 32'd1, 1'b1);
      i_stall = 1; i_fwd_a = 2'd2; i_memwb_data = 32'h5555_0000;
      cycle("stall1");
      i_flush = 1;
      cycle("stall_flush");
      check("flush_valid_const", 32'(o_valid), 32'd0);
      i_flush = 0;
      cycle("stall3");

      // Reserved opcode, with and without a valid instruction.
      drive(6'h3F, 6'h00, 5'd3, 1'b0, 16'h7777, 32'd1, 32'd2, 1'b1);
      cycle("illegal_v");
      check("illegal_v_const", 32'(o_illegal), 32'd1);
      drive(6'h3F, 6'h00, 5'd3, 1'b0, 16'h7777, 32'd1, 32'd2, 1'b0);
      cycle("illegal_nv");

      // SRL with i_rot set.
      drive(6'h00, 6'h02, 5'd8, 1'b1, 16'h0000, 32'd0, 32'h1234_5678, 1'b1);
      cycle("rotr");
`ifdef ALU_CTRL_ROTATE_EN
      check("rotr_shift_const", 32'(o_shift_op), 32'd3);
`else
      check("rotr_shift_const", 32'(o_shift_op), 32'd1);
`endif

      // Asynchronous reset in the middle of a cycle.
      drive(6'h00, 6'h20, 5'd0, 1'b0, 16'h0000, 32'd10, 32'd20, 1'b1);
      cycle("pre_rst");
      #2 i_rst_n = 0;
      st = '0;
      #1 compare_all("async_rst");
      @(negedge i_clk);
      i_rst_n = 1;
      drive(6'h0D, 6'h00, 5'd0, 1'b0, 16'h00F0, 32'h0F00, 32'd0, 1'b1);
      cycle("post_rst");

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         logic [5:0] op, fn;
         op = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 12)];
         fn = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63)) : fns[$urandom_range(0, 15)];
         drive(op, fn, 5'($urandom), 1'($urandom), 16'($urandom), $urandom, $urandom,
               1'($urandom_range(0, 5) != 0));
         i_stall = ($urandom_range(0, 7) == 0);
         i_flush = ($urandom_range(0, 15) == 0);
         i_fwd_a = 2'($urandom); i_fwd_b = 2'($urandom);
         i_exmem_data = $urandom; i_memwb_data = $urandom;
         cycle("rand");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
